// File: rtl/dmem_map_pkg.sv
// Memory map for the data-memory / pixel MMIO block.
// Address constants, STATUS bit positions and decode regions.
package dmem_map_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] RXDATA_ADDR = 32'h8000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0008;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;
  localparam int ST_CNT_W    = 6;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_TX,
    REG_RX,
    REG_STAT,
    REG_NONE
  } region_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, with occupancy count.
// Ports: push/din in, pop in, full/empty/count/head out.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [AW:0]   C1 = (AW+1)'(1);
  localparam logic [AW:0]   CD = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CD);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + P1;
      if (pop_ok)  rd_ptr <= rd_ptr + P1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + C1;
        2'b01:   cnt <= cnt - C1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data RAM plus memory-mapped TX/RX pixel FIFOs for a single-cycle core.
// CPU side: MemWrite/MemRead/ALUResult/WriteData/ReadData; px_out_*/px_in_* streams.
module dmem_mmio_ctrl
  import dmem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [PIX_W-1:0] px_out_data,
  output logic             px_out_valid,
  input  logic             px_out_ready,
  input  logic [PIX_W-1:0] px_in_data,
  input  logic             px_in_valid,
  output logic             px_in_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     ram [RAM_WORDS];
  logic [31:0]     waddr;
  logic [RAW-1:0]  ram_idx;
  logic            ram_hit;
  logic            unused_addr_lsb;
  region_e         region;

  logic            tx_push;
  logic            rx_pop;
  logic            stat_wr;
  logic            ram_we;

  logic            tx_full;
  logic            tx_empty;
  logic [CW-1:0]   tx_count;
  logic [PIX_W-1:0] tx_head;
  logic            rx_full;
  logic            rx_empty;
  logic [CW-1:0]   rx_count;
  logic [PIX_W-1:0] rx_head;

  logic            tx_ovf;
  logic            rx_unf;
  logic [31:0]     status;

  assign waddr           = {ALUResult[31:2], 2'b00};
  assign ram_idx         = ALUResult[RAW+1:2];
  assign ram_hit         = (ALUResult[31:RAW+2] == '0);
  assign unused_addr_lsb = ^ALUResult[1:0];

  always_comb begin
    region = REG_NONE;
    unique case (1'b1)
      ram_hit:                 region = REG_RAM;
      (waddr == TXDATA_ADDR):  region = REG_TX;
      (waddr == RXDATA_ADDR):  region = REG_RX;
      (waddr == STATUS_ADDR):  region = REG_STAT;
      default:                 region = REG_NONE;
    endcase
  end

  assign tx_push = MemWrite && (region == REG_TX);
  assign rx_pop  = MemRead  && (region == REG_RX);
  assign stat_wr = MemWrite && (region == REG_STAT);
  assign ram_we  = MemWrite && (region == REG_RAM);

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= WriteData;
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_tx (
    .clk   (clk),
    .rst_n (reset),
    .push  (tx_push),
    .din   (WriteData[PIX_W-1:0]),
    .pop   (px_out_ready),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_rx (
    .clk   (clk),
    .rst_n (reset),
    .push  (px_in_valid),
    .din   (px_in_data),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  assign px_out_data  = tx_head;
  assign px_out_valid = !tx_empty;
  assign px_in_ready  = !rx_full;

  // A new event in the same cycle as a W1C wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      tx_ovf <= (tx_ovf && !(stat_wr && WriteData[ST_TX_OVF]))
              || (tx_push && tx_full);
      rx_unf <= (rx_unf && !(stat_wr && WriteData[ST_RX_UNF]))
              || (rx_pop && rx_empty);
    end
  end

  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_UNF]   = rx_unf;
    status[ST_TX_CNT +: ST_CNT_W] = ST_CNT_W'(tx_count);
    status[ST_RX_CNT +: ST_CNT_W] = ST_CNT_W'(rx_count);
  end

  // Empty RX head is already 0, so an underflowing load reads 0.
  always_comb begin
    ReadData = '0;
    unique case (region)
      REG_RAM:  ReadData = ram[ram_idx];
      REG_RX:   ReadData = {{(32-PIX_W){1'b0}}, rx_head};
      REG_STAT: ReadData = status;
      default:  ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Self-checking bench for dmem_mmio_ctrl: vector table plus
// scoreboarded TX/RX pixel sequences.
module tb_dmem_mmio_ctrl;

  localparam logic [31:0] TXA = 32'h8000_0000;
  localparam logic [31:0] RXA = 32'h8000_0004;
  localparam logic [31:0] STA = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  px_out_data;
  logic        px_out_valid;
  logic        px_out_ready = 1'b0;
  logic [7:0]  px_in_data = '0;
  logic        px_in_valid = 1'b0;
  logic        px_in_ready;

  always #5 clk = ~clk;

  dmem_mmio_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .px_out_data  (px_out_data),
    .px_out_valid (px_out_valid),
    .px_out_ready (px_out_ready),
    .px_in_data   (px_in_data),
    .px_in_valid  (px_in_valid),
    .px_in_ready  (px_in_ready)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vt [11];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic [31:0] exp_rx;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic ordy, input logic ivld,
                       input logic [7:0] idat);
    int sz;
    @(negedge clk);
    MemWrite     = we;
    MemRead      = re;
    ALUResult    = a;
    WriteData    = d;
    px_out_ready = ordy;
    px_in_valid  = ivld;
    px_in_data   = idat;
    if (we && {a[31:2], 2'b00} == TXA && tx_q.size() < 16)
      tx_q.push_back(d[7:0]);
    sz = rx_q.size();
    exp_rx = '0;
    if (re && {a[31:2], 2'b00} == RXA && sz != 0)
      exp_rx = {24'b0, rx_q.pop_front()};
    if (ivld && sz < 16)
      rx_q.push_back(idat);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 32'h0, 32'h0, ordy, 1'b0, 8'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0, 1'b0, 8'h0);
  endtask

  // TX scoreboard: compare each pixel the DUT hands off.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && px_out_valid && px_out_ready) begin
        if (tx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got %h want none", px_out_data);
        end else begin
          chk("tx_px", 32'(px_out_data), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    vt[0]  = '{1, 0, 32'h14, 32'hCAFEF00D, 0, 32'h0, "ram_w14"};
    vt[1]  = '{1, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, "ram_w10"};
    vt[2]  = '{0, 1, 32'h10, 32'h0, 1, 32'hDEADBEEF, "ram_r10"};
    vt[3]  = '{0, 1, 32'h13, 32'h0, 1, 32'hDEADBEEF, "ram_r13"};
    vt[4]  = '{0, 1, 32'h14, 32'h0, 1, 32'hCAFEF00D, "ram_r14"};
    vt[5]  = '{0, 1, 32'h1000, 32'h0, 1, 32'h0, "unmapped_r"};
    vt[6]  = '{1, 0, 32'h1010, 32'h0BADF00D, 0, 32'h0, "unmapped_w"};
    vt[7]  = '{0, 1, 32'h10, 32'h0, 1, 32'hDEADBEEF, "no_alias"};
    vt[8]  = '{0, 1, TXA, 32'h0, 1, 32'h0, "txdata_r"};
    vt[9]  = '{0, 1, STA, 32'h0, 1, 32'h0000_000A, "stat_rst"};
    vt[10] = '{1, 0, TXA, 32'h1A5, 0, 32'h0, "tx_push"};

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(px_out_valid), 32'h0);
    chk("rst_data", 32'(px_out_data), 32'h0);
    chk("rst_ready", 32'(px_in_ready), 32'h1);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata,
            1'b0, 1'b0, 8'h0);
      if (vt[i].chk) chk(vt[i].name, ReadData, vt[i].exp);
    end

    // Single TX pixel then one ready cycle.
    rd(STA);
    chk("tx1_stat", ReadData, 32'h0000_0108);
    chk("tx1_valid", 32'(px_out_valid), 32'h1);
    chk("tx1_data", 32'(px_out_data), 32'h0000_00A5);
    idle(1'b1);
    idle(1'b0);
    chk("tx1_drained", 32'(px_out_valid), 32'h0);
    rd(STA);
    chk("tx1_stat0", ReadData, 32'h0000_000A);

    // Overflow: 17th store dropped, flag sticky until W1C.
    for (int i = 0; i < 17; i++) wr(TXA, 32'h130 + 32'(i));
    rd(STA);
    chk("ovf_stat", ReadData, 32'h0000_1019);
    chk("ovf_head", 32'(px_out_data), 32'h0000_0030);
    wr(STA, 32'h10);
    rd(STA);
    chk("ovf_clr", ReadData, 32'h0000_1009);
    for (int i = 0; i < 16; i++) idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("ovf_empty", 32'(px_out_valid), 32'h0);
    chk("ovf_sb", 32'(tx_q.size()), 32'h0);
    idle(1'b0);

    // RX stream in, CPU pops, underflow.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h22);
    rd(STA);
    chk("rx2_stat", ReadData, 32'h0002_0002);
    rd(RXA);
    chk("rx_pop0", ReadData, exp_rx);
    chk("rx_pop0k", ReadData, 32'h11);
    rd(RXA);
    chk("rx_pop1", ReadData, 32'h22);
    rd(STA);
    chk("rx_empty", ReadData, 32'h0000_000A);
    rd(RXA);
    chk("rx_unf_rd", ReadData, 32'h0);
    rd(STA);
    chk("rx_unf", ReadData, 32'h0000_002A);
    wr(STA, 32'h20);
    rd(STA);
    chk("rx_unf_clr", ReadData, 32'h0000_000A);

    // Full RX with simultaneous stream push and CPU pop.
    for (int i = 0; i < 16; i++)
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h50 + 8'(i));
    rd(STA);
    chk("rxf_stat", ReadData, 32'h0010_0006);
    chk("rxf_ready", 32'(px_in_ready), 32'h0);
    drive(1'b0, 1'b1, RXA, 32'h0, 1'b0, 1'b1, 8'hEE);
    chk("rxs_ready", 32'(px_in_ready), 32'h0);
    chk("rxs_data", ReadData, 32'h50);
    rd(STA);
    chk("rxs_stat", ReadData, 32'h000F_0002);
    for (int i = 0; i < 15; i++) begin
      rd(RXA);
      chk("rxs_drain", ReadData, exp_rx);
    end
    rd(STA);
    chk("rxs_done", ReadData, 32'h0000_000A);

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) wr(TXA, 32'h60 + 32'(i));
    drive(1'b0, 1'b1, STA, 32'h0, 1'b0, 1'b1, 8'h77);
    chk("pre_rst_valid", 32'(px_out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(px_out_valid), 32'h0);
    chk("arst_data", 32'(px_out_data), 32'h0);
    chk("arst_ready", 32'(px_in_ready), 32'h1);
    chk("arst_stat", ReadData, 32'h0000_000A);
    tx_q.delete();
    rx_q.delete();
    @(negedge clk);
    reset = 1'b1;
    rd(32'h10);
    chk("ram_kept", ReadData, 32'hDEADBEEF);
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_valid", 32'(px_out_valid), 32'h0);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
